// File: rtl/mux_lut_pkg.sv
// Shared types and helpers for the mux-based programmable LUT unit.
// Holds the FSM state type, table depth helper and reset table pattern.
package mux_lut_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Truth table depth for K select inputs (T = 1 << K).
    function automatic int lut_depth(input int k);
        return 1 << k;
    endfunction

    // Inverter pattern: entry j is the NOT of select bit 0.
    // Sized for the largest legal K (6); callers keep the low T bits.
    function automatic logic [63:0] default_table(input int k);
        logic [63:0] t;
        t = '0;
        for (int j = 0; j < (1 << k); j++) begin
            t[j] = ~j[0];
        end
        return t;
    endfunction

endpackage

// File: rtl/mux_lut_lane.sv
// One lane of the LUT: a K-level 2:1 mux tree selecting a table bit.
// Ports: tbl (2^K truth table), sel (K-bit select), y (selected bit).
module mux_lut_lane
    import mux_lut_pkg::*;
#(
    parameter int K = 2
) (
    input  logic [(1<<K)-1:0] tbl,
    input  logic [K-1:0]      sel,
    output logic              y
);

    localparam int T = lut_depth(K);

    logic [T-1:0] level;

    // Each pass halves the live width; select bit l picks odd/even leaf.
    // Writes go to index j while reads come from 2j and 2j+1 (>= j),
    // so the in-place reduction never reads an already-updated entry.
    always_comb begin
        level = tbl;
        for (int l = 0; l < K; l++) begin
            for (int j = 0; j < T / 2; j++) begin
                level[j] = sel[l] ? level[2*j+1] : level[2*j];
            end
        end
        y = level[0];
    end

endmodule

// File: rtl/mux_lut_unit.sv
// W-lane registered LUT sharing one 2^K truth table, with serial reload.
// Ports: clk, rst_n (sync, active low); cfg_start/cfg_valid/cfg_bit load
// the table, index 0 first; cfg_busy/cfg_done report reconfiguration;
// in_valid/in_ready/in_data feed selects; out_valid/out_ready/out_data
// hold results. Macro MUX_LUT_CFG_READBACK_EN adds cfg_rd (live table).
module mux_lut_unit
    import mux_lut_pkg::*;
#(
    parameter int K = 2,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W*K-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data
`ifdef MUX_LUT_CFG_READBACK_EN
    ,
    output logic [(1<<K)-1:0] cfg_rd
`endif
);

    localparam int T = lut_depth(K);
    localparam logic [63:0]  DEF_ALL = default_table(K);
    localparam logic [T-1:0] DEF     = DEF_ALL[T-1:0];
    localparam logic [K:0]   LAST    = (K+1)'(T - 1);

    state_t       state;
    logic [T-1:0] lut_q;
    logic [T-1:0] shadow;
    logic [T-1:0] shadow_nxt;
    logic [K:0]   count;
    logic [W-1:0] lookup;
    logic         accept;
    logic         drain;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_lane
            mux_lut_lane #(.K(K)) u_lane (
                .tbl (lut_q),
                .sel (in_data[i*K +: K]),
                .y   (lookup[i])
            );
        end
    endgenerate

    assign cfg_busy = (state != RUN);
    // cfg_start blocks acceptance so a reload never races a new word.
    assign in_ready = (state == RUN) && !cfg_start
                   && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

`ifdef MUX_LUT_CFG_READBACK_EN
    assign cfg_rd = lut_q;
`endif

    // Shadow including the bit arriving this cycle, so the commit
    // on the last bit copies a complete table in one edge.
    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[count[K-1:0]] = cfg_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_done  <= 1'b0;
            count     <= '0;
            lut_q     <= DEF;
            shadow    <= DEF;
        end else begin
            cfg_done <= 1'b0;

            if (accept) begin
                out_data  <= lookup;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end

            unique case (state)
                RUN: begin
                    if (cfg_start) begin
                        state <= out_valid ? DRAIN : LOAD;
                    end
                end
                DRAIN: begin
                    if (!out_valid) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        shadow <= shadow_nxt;
                        if (count == LAST) begin
                            lut_q    <= shadow_nxt;
                            count    <= '0;
                            state    <= RUN;
                            cfg_done <= 1'b1;
                        end else begin
                            count <= count + (K+1)'(1);
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_lut_unit.sv
// Directed bench for mux_lut_unit: K=2/W=4 instance plus K=3/W=1 parity.
// Scoreboard queues hold expected words, popped on each output transfer.
module tb_mux_lut_unit;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       cfg_start, cfg_valid, cfg_bit, cfg_busy, cfg_done;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data;
    logic [3:0] out_data;

    logic       cfg_start3, cfg_valid3, cfg_bit3, cfg_busy3, cfg_done3;
    logic       in_valid3, in_ready3, out_valid3, out_ready3;
    logic [2:0] in_data3;
    logic [0:0] out_data3;

`ifdef MUX_LUT_CFG_READBACK_EN
    logic [3:0] cfg_rd;
    logic [7:0] cfg_rd3;
`endif

    int checks = 0;
    int errors = 0;
    int acc4   = 0;
    int pops4  = 0;
    int pops3  = 0;

    logic [3:0] mtab;
    logic [3:0] q[$];
    logic       q3[$];

    always #5 clk = ~clk;

    mux_lut_unit #(.K(2), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MUX_LUT_CFG_READBACK_EN
        ,
        .cfg_rd    (cfg_rd)
`endif
    );

    mux_lut_unit #(.K(3), .W(1)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start3),
        .cfg_valid (cfg_valid3),
        .cfg_bit   (cfg_bit3),
        .cfg_busy  (cfg_busy3),
        .cfg_done  (cfg_done3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3)
`ifdef MUX_LUT_CFG_READBACK_EN
        ,
        .cfg_rd    (cfg_rd3)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model4(input logic [7:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = mtab[d[i*2 +: 2]];
        end
        return r;
    endfunction

    // One clock: score handshakes seen before the edge, then step.
    task automatic tick();
        logic [3:0] e;
        logic       e3;
        #1;
        if (out_valid && out_ready) begin
            check("sb4_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sb4_data", 64'(out_data), 64'(e));
            end
            pops4++;
        end
        if (in_valid && in_ready) begin
            q.push_back(model4(in_data));
            acc4++;
        end
        if (out_valid3 && out_ready3) begin
            check("sb3_nonempty", 64'(q3.size() != 0), 64'd1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                check("sb3_data", 64'(out_data3), 64'(e3));
            end
            pops3++;
        end
        if (in_valid3 && in_ready3) begin
            q3.push_back(^in_data3);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            q3.delete();
        end
    endtask

    // Shift n table bits (index 0 first) with one stall after bit 1.
    task automatic send_bits(input logic [7:0] bits, input int n,
                             input bit to3);
        for (int b = 0; b < n; b++) begin
            if (to3) begin
                cfg_valid3 = 1'b1;
                cfg_bit3   = bits[b];
            end else begin
                cfg_valid = 1'b1;
                cfg_bit   = bits[b];
            end
            tick();
            if (b == 1) begin
                cfg_valid  = 1'b0;
                cfg_valid3 = 1'b0;
                tick();
                check("stall_busy", 64'(to3 ? cfg_busy3 : cfg_busy), 64'd1);
            end
        end
        cfg_valid  = 1'b0;
        cfg_valid3 = 1'b0;
        check("done_pulse", 64'(to3 ? cfg_done3 : cfg_done), 64'd1);
        check("busy_drop", 64'(to3 ? cfg_busy3 : cfg_busy), 64'd0);
        tick();
        check("done_once", 64'(to3 ? cfg_done3 : cfg_done), 64'd0);
        if (!to3) mtab = bits[3:0];
    endtask

    task automatic start_cfg(input bit to3);
        if (to3) cfg_start3 = 1'b1;
        else     cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        cfg_start3 = 1'b0;
    endtask

    task automatic one_word(input string tag, input logic [7:0] d,
                            input logic [3:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        tick();
    endtask

    logic [7:0] w[3];
    int         base;
    int         p0;

    initial begin
        rst_n = 1'b0;
        cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
        in_valid = 0; in_data = '0; out_ready = 0;
        cfg_start3 = 0; cfg_valid3 = 0; cfg_bit3 = 0;
        in_valid3 = 0; in_data3 = '0; out_ready3 = 0;
        mtab = 4'b0101;
        tick();
        tick();

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(cfg_busy), 64'd0);
        check("rst_done", 64'(cfg_done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid3", 64'(out_valid3), 64'd0);
`ifdef MUX_LUT_CFG_READBACK_EN
        check("rst_cfg_rd", 64'(cfg_rd), 64'h5);
        check("rst_cfg_rd3", 64'(cfg_rd3), 64'h55);
`endif

        rst_n = 1'b1;
        // Stray config bit in RUN must not touch the table.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_valid = 1'b0;

        one_word("inv", 8'b11_10_01_00, 4'b0101);
        check("inv_idle", 64'(out_valid), 64'd0);

        start_cfg(1'b0);
        check("load_busy", 64'(cfg_busy), 64'd1);
        check("load_in_ready", 64'(in_ready), 64'd0);
        send_bits(8'b0000_1000, 4, 1'b0);
        one_word("and", 8'b11_10_01_00, 4'b1000);

        // Backpressure: three words against a stalled sink.
        w[0] = 8'b11_11_11_11;
        w[1] = 8'b00_11_00_11;
        w[2] = 8'b11_00_00_00;
        base = acc4;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = w[acc4 - base];
            tick();
        end
        check("bp_accepted", 64'(acc4 - base), 64'd1);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold", 64'(out_data), 64'h f);
        out_ready = 1'b1;
        p0 = pops4;
        for (int c = 0; c < 3; c++) begin
            in_valid = (acc4 - base) < 3;
            if (acc4 - base < 3) in_data = w[acc4 - base];
            tick();
        end
        in_valid = 1'b0;
        check("bp_rate", 64'(pops4 - p0), 64'd3);
        check("bp_all_in", 64'(acc4 - base), 64'd3);
        check("bp_empty", 64'(out_valid), 64'd0);

        // cfg_start with a stuck result goes through DRAIN first.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'b00_01_10_11;
        tick();
        in_valid = 1'b0;
        start_cfg(1'b0);
        check("drain_busy", 64'(cfg_busy), 64'd1);
        check("drain_in_ready", 64'(in_ready), 64'd0);
        check("drain_held", 64'(out_valid), 64'd1);
        tick();
        check("drain_still", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check("drain_cleared", 64'(out_valid), 64'd0);
        tick();
        send_bits(8'b0000_1110, 4, 1'b0);
        one_word("or", 8'b11_10_01_00, 4'b1110);

        // Reset with a word stuck in the output register.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'b11_11_11_11;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mtab  = 4'b0101;
        check("rstw_lost", 64'(out_valid), 64'd0);

        // Reset mid-load after two of four bits.
        start_cfg(1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        tick();
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstl_busy", 64'(cfg_busy), 64'd0);
        check("rstl_done", 64'(cfg_done), 64'd0);
        check("rstl_data", 64'(out_data), 64'd0);
        check("rstl_in_ready", 64'(in_ready), 64'd1);
        one_word("rstl_inv", 8'b11_10_01_00, 4'b0101);
        start_cfg(1'b0);
        send_bits(8'b0000_0110, 4, 1'b0);
        one_word("xor2", 8'b11_10_01_00, 4'b0110);

        // K=3 parity table on the second instance.
        start_cfg(1'b1);
        send_bits(8'b1001_0110, 8, 1'b1);
`ifdef MUX_LUT_CFG_READBACK_EN
        check("cfg_rd3", 64'(cfg_rd3), 64'h96);
        check("cfg_rd_xor2", 64'(cfg_rd), 64'h6);
`endif
        out_ready3 = 1'b1;
        p0 = pops3;
        for (int s = 0; s < 8; s++) begin
            in_valid3 = 1'b1;
            in_data3  = 3'(s);
            tick();
        end
        in_valid3 = 1'b0;
        tick();
        check("par_count", 64'(pops3 - p0), 64'd8);
        check("sb4_drained", 64'(q.size()), 64'd0);
        check("sb3_drained", 64'(q3.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
